// File: rtl/id_issue_if.sv
// Decoder/issue/debug signal bundle for the issue-side controller.
// The slave modport is the controller's view; master is the environment's view.
interface id_issue_if #(
  parameter int DATA_W = 64
);
  logic              flush_i;
  logic              dec_valid_i;
  logic              dec_ready_o;
  logic [DATA_W-1:0] dec_data_i;
  logic              dec_cf_i;
  logic              iss_valid_o;
  logic [DATA_W-1:0] iss_data_o;
  logic              iss_cf_o;
  logic              iss_ack_i;
  logic              cf_resolve_i;
  logic              halt_req_i;
  logic              resume_i;
  logic              halted_o;
  logic [2:0]        cf_pending_o;

  modport slave (
    input  flush_i, dec_valid_i, dec_data_i, dec_cf_i, iss_ack_i,
           cf_resolve_i, halt_req_i, resume_i,
    output dec_ready_o, iss_valid_o, iss_data_o, iss_cf_o, halted_o,
           cf_pending_o
  );

  modport master (
    output flush_i, dec_valid_i, dec_data_i, dec_cf_i, iss_ack_i,
           cf_resolve_i, halt_req_i, resume_i,
    input  dec_ready_o, iss_valid_o, iss_data_o, iss_cf_o, halted_o,
           cf_pending_o
  );
endinterface

// File: rtl/id_issue_ctrl.sv
// Issue-side controller: decoded-instruction FIFO, control-flow in-flight limiter
// and debug halt sequencer (RUN -> DRAIN -> HALTED -> RUN).
//
// state   | meaning
// RUN     | normal intake and issue
// DRAIN   | intake stopped, buffered entries still issue, waiting for cf resolves
// HALTED  | pipeline empty, no intake, no issue, waiting for resume
module id_issue_ctrl #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int MAX_CF = 1
) (
  input logic        clk_i,
  input logic        rst_i,
  id_issue_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]  mem_cf;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [2:0]        cf_pending;
  logic [1:0]        state;

  logic empty;
  logic full;
  logic head_cf;
  logic cf_room;
  logic enq;
  logic deq;
  logic cf_inc;
  logic cf_dec;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head_cf = mem_cf[rd_ptr];
  assign cf_room = (cf_pending < 3'(MAX_CF));

  // Ready looks only at registered state and flush, never at the issue ack.
  assign bus.dec_ready_o  = !full && (state == ST_RUN) && !bus.flush_i;
  assign bus.iss_valid_o  = !empty && (state != ST_HALTED) && !bus.flush_i &&
                            (!head_cf || cf_room);
  assign bus.iss_data_o   = empty ? '0 : mem_data[rd_ptr];
  assign bus.iss_cf_o     = empty ? 1'b0 : head_cf;
  assign bus.halted_o     = (state == ST_HALTED);
  assign bus.cf_pending_o = cf_pending;

  assign enq    = bus.dec_valid_i && bus.dec_ready_o;
  assign deq    = bus.iss_valid_o && bus.iss_ack_i;
  assign cf_inc = deq && head_cf;
  assign cf_dec = bus.cf_resolve_i && (cf_pending != 3'd0);

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_data[wr_ptr] <= bus.dec_data_i;
      mem_cf[wr_ptr]   <= bus.dec_cf_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A resolve arriving at zero is spurious, so an ack in that cycle still counts up.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cf_pending <= 3'd0;
    end else if (bus.flush_i) begin
      cf_pending <= 3'd0;
    end else if (cf_inc && !cf_dec) begin
      cf_pending <= cf_pending + 3'd1;
    end else if (cf_dec && !cf_inc) begin
      cf_pending <= cf_pending - 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.halt_req_i) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bus.flush_i || (empty && (cf_pending == 3'd0))) state <= ST_HALTED;
        end
        ST_HALTED: begin
          if (bus.resume_i) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Scoreboard bench for id_issue_ctrl: accepted instructions are queued at the
// decoder handshake and compared in order at the issue handshake.
module tb_id_issue_ctrl;

  localparam int DATA_W = 64;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              cf;
    int                cyc;
  } sb_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cyc;
  bit   lat_exact;
  sb_t  sb[$];
  sb_t  sb_head;

  id_issue_if #(.DATA_W(DATA_W)) bus ();

  id_issue_ctrl #(
    .DATA_W(DATA_W),
    .DEPTH (2),
    .MAX_CF(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Handshakes are sampled mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    if (rst || bus.flush_i) begin
      sb.delete();
    end else begin
      if (bus.iss_valid_o && bus.iss_ack_i) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          sb_head = sb.pop_front();
          chk("iss_data", bus.iss_data_o, sb_head.data);
          chk("iss_cf", 64'(bus.iss_cf_o), 64'(sb_head.cf));
          if (lat_exact) chk("lat_exact", 64'(cyc), 64'(sb_head.cyc + 1));
          else           chk("lat_min", 64'(cyc > sb_head.cyc), 64'd1);
        end
      end
      if (bus.dec_valid_i && bus.dec_ready_o)
        sb.push_back('{bus.dec_data_i, bus.dec_cf_i, cyc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    lat_exact = 1'b0;
    rst = 1'b1;
    bus.flush_i = 0; bus.dec_valid_i = 0; bus.dec_data_i = '0; bus.dec_cf_i = 0;
    bus.iss_ack_i = 0; bus.cf_resolve_i = 0; bus.halt_req_i = 0; bus.resume_i = 0;

    #2;
    chk("rst_ready", 64'(bus.dec_ready_o), 64'd1);
    chk("rst_valid", 64'(bus.iss_valid_o), 64'd0);
    chk("rst_data", bus.iss_data_o, 64'd0);
    chk("rst_cf", 64'(bus.iss_cf_o), 64'd0);
    chk("rst_halted", 64'(bus.halted_o), 64'd0);
    chk("rst_pending", 64'(bus.cf_pending_o), 64'd0);
    tick();
    rst = 1'b0;

    // streaming
    lat_exact = 1'b1;
    bus.dec_valid_i = 1; bus.iss_ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      bus.dec_data_i = 64'h1000 + 64'(i);
      #1 chk("stream_ready", 64'(bus.dec_ready_o), 64'd1);
      tick();
    end
    bus.dec_valid_i = 0;
    drain("stream_drain");
    lat_exact = 1'b0;

    // backpressure / full
    bus.iss_ack_i = 0; bus.dec_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      bus.dec_data_i = 64'h2000 + 64'(i);
      #1 chk("bp_ready", 64'(bus.dec_ready_o), (i < 2) ? 64'd1 : 64'd0);
      tick();
    end
    chk("bp_accepted", 64'(sb.size()), 64'd2);
    bus.dec_valid_i = 0; bus.iss_ack_i = 1;
    #1 chk("bp_full_deq_ready", 64'(bus.dec_ready_o), 64'd0);
    drain("bp_drain");
    #1 chk("bp_ready_after", 64'(bus.dec_ready_o), 64'd1);
    chk("bp_valid_after", 64'(bus.iss_valid_o), 64'd0);

    // control-flow limit
    bus.iss_ack_i = 1; bus.dec_valid_i = 1; bus.dec_cf_i = 1; bus.dec_data_i = 64'hA;
    tick();
    bus.dec_data_i = 64'hB;
    tick();
    bus.dec_valid_i = 0; bus.dec_cf_i = 0;
    #1 chk("cf_pending_a", 64'(bus.cf_pending_o), 64'd1);
    chk("cf_b_blocked", 64'(bus.iss_valid_o), 64'd0);
    tick();
    chk("cf_b_held", 64'(bus.iss_valid_o), 64'd0);
    bus.cf_resolve_i = 1;
    #1 chk("cf_b_resolve_cycle", 64'(bus.iss_valid_o), 64'd0);
    tick();
    #1 chk("cf_b_released", 64'(bus.iss_valid_o), 64'd1);
    chk("cf_pending_zero", 64'(bus.cf_pending_o), 64'd0);
    tick();
    bus.cf_resolve_i = 0;
    #1 chk("cf_ack_and_resolve", 64'(bus.cf_pending_o), 64'd1);
    bus.cf_resolve_i = 1;
    tick();
    bus.cf_resolve_i = 0;
    #1 chk("cf_resolve_b", 64'(bus.cf_pending_o), 64'd0);
    bus.cf_resolve_i = 1;
    tick();
    bus.cf_resolve_i = 0;
    #1 chk("cf_no_underflow", 64'(bus.cf_pending_o), 64'd0);
    chk("cf_sb_empty", 64'(sb.size()), 64'd0);

    // flush
    bus.iss_ack_i = 1; bus.dec_valid_i = 1; bus.dec_cf_i = 1; bus.dec_data_i = 64'hC;
    tick();
    bus.dec_cf_i = 0; bus.dec_data_i = 64'hD1;
    tick();
    bus.iss_ack_i = 0; bus.dec_data_i = 64'hD2;
    tick();
    bus.dec_valid_i = 0;
    #1 chk("fl_two_buffered", 64'(sb.size()), 64'd2);
    chk("fl_pending_before", 64'(bus.cf_pending_o), 64'd1);
    bus.flush_i = 1; bus.iss_ack_i = 1;
    #1 chk("fl_valid_same", 64'(bus.iss_valid_o), 64'd0);
    chk("fl_ready_same", 64'(bus.dec_ready_o), 64'd0);
    tick();
    bus.flush_i = 0; bus.iss_ack_i = 0;
    #1 chk("fl_valid_next", 64'(bus.iss_valid_o), 64'd0);
    chk("fl_data_next", bus.iss_data_o, 64'd0);
    chk("fl_pending_next", 64'(bus.cf_pending_o), 64'd0);
    chk("fl_ready_next", 64'(bus.dec_ready_o), 64'd1);

    // debug halt
    bus.iss_ack_i = 1; bus.dec_valid_i = 1; bus.dec_cf_i = 1; bus.dec_data_i = 64'hE;
    tick();
    bus.dec_cf_i = 0; bus.dec_data_i = 64'hF1;
    tick();
    bus.iss_ack_i = 0; bus.dec_data_i = 64'hF2;
    tick();
    bus.dec_valid_i = 0; bus.halt_req_i = 1;
    tick();
    #1 chk("halt_ready", 64'(bus.dec_ready_o), 64'd0);
    chk("halt_drain_valid", 64'(bus.iss_valid_o), 64'd1);
    chk("halt_not_yet", 64'(bus.halted_o), 64'd0);
    bus.iss_ack_i = 1;
    drain("halt_drain");
    bus.iss_ack_i = 0;
    #1 chk("halt_wait_cf", 64'(bus.halted_o), 64'd0);
    bus.cf_resolve_i = 1;
    tick();
    bus.cf_resolve_i = 0;
    #1 chk("halt_resolve_cycle", 64'(bus.halted_o), 64'd0);
    tick();
    #1 chk("halt_parked", 64'(bus.halted_o), 64'd1);
    chk("halt_parked_ready", 64'(bus.dec_ready_o), 64'd0);
    bus.resume_i = 1;
    tick();
    bus.resume_i = 0;
    #1 chk("resume_halted", 64'(bus.halted_o), 64'd0);
    chk("resume_ready", 64'(bus.dec_ready_o), 64'd1);
    tick();
    #1 chk("rehalt_drain_ready", 64'(bus.dec_ready_o), 64'd0);
    tick();
    #1 chk("rehalt_parked", 64'(bus.halted_o), 64'd1);
    bus.halt_req_i = 0; bus.resume_i = 1;
    tick();
    bus.resume_i = 0;
    #1 chk("resume2_halted", 64'(bus.halted_o), 64'd0);
    chk("resume2_ready", 64'(bus.dec_ready_o), 64'd1);

    // reset in DRAIN with a full FIFO
    bus.dec_valid_i = 1; bus.dec_data_i = 64'h51;
    tick();
    bus.dec_data_i = 64'h52;
    tick();
    bus.dec_valid_i = 0; bus.halt_req_i = 1;
    tick();
    #1 chk("rd_drain_valid", 64'(bus.iss_valid_o), 64'd1);
    rst = 1'b1;
    #1 chk("rd_ready", 64'(bus.dec_ready_o), 64'd1);
    chk("rd_valid", 64'(bus.iss_valid_o), 64'd0);
    chk("rd_data", bus.iss_data_o, 64'd0);
    chk("rd_cf", 64'(bus.iss_cf_o), 64'd0);
    chk("rd_halted", 64'(bus.halted_o), 64'd0);
    chk("rd_pending", 64'(bus.cf_pending_o), 64'd0);
    bus.halt_req_i = 0;
    tick();
    rst = 1'b0;
    #1 chk("rd_run_ready", 64'(bus.dec_ready_o), 64'd1);
    bus.dec_valid_i = 1; bus.iss_ack_i = 1; bus.dec_data_i = 64'h60;
    tick();
    bus.dec_valid_i = 0;
    drain("rd_post_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
